// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the fetch/next-PC path of the single-issue core.
// The opcode/funct values select the instruction classes the sequencer cares about.
// The PC_* codes are the pc_control encoding that program_counter decodes.
// -----------------------------------------------------------------------------
package cpu_defs;

    // Opcode field instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    // Funct field instr[5:0] (R-type only)
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    // pc_control codes understood by program_counter
    localparam logic [2:0] PC_SEQ   = 3'b000;
    localparam logic [2:0] PC_JMP   = 3'b001;
    localparam logic [2:0] PC_REG   = 3'b010;
    localparam logic [2:0] PC_BR    = 3'b011;

    typedef enum logic [2:0] {
        ST_RESET_WAIT = 3'd0,
        ST_FETCH      = 3'd1,
        ST_DECODE     = 3'd2,
        ST_RESOLVE    = 3'd3,
        ST_UPDATE     = 3'd4,
        ST_HALT       = 3'd5
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_classifier.sv
// -----------------------------------------------------------------------------
// instr_classifier
// Purely combinational decode of an instruction's opcode/funct into the control
// the sequencer needs.
//   op_i             in   6  instr[31:26]
//   funct_i          in   6  instr[5:0]
//   ctl_o            out  3  pc_control to use if no resolution changes it
//   needs_resolve_o  out  1  instruction must wait for branch or register result
//   is_branch_o      out  1  resolution comes from branch_valid (else reg_valid)
// -----------------------------------------------------------------------------
module instr_classifier
    import cpu_defs::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] ctl_o,
    output logic       needs_resolve_o,
    output logic       is_branch_o
);

    always_comb begin
        ctl_o           = PC_SEQ;
        needs_resolve_o = 1'b0;
        is_branch_o     = 1'b0;
        case (op_i)
            OP_J, OP_JAL: begin
                ctl_o = PC_JMP;
            end
            // Branch direction is unknown here; the final code is chosen in RESOLVE.
            OP_BEQ, OP_BNE: begin
                needs_resolve_o = 1'b1;
                is_branch_o     = 1'b1;
            end
            OP_RTYPE: begin
                if (funct_i == FN_JR || funct_i == FN_JALR) begin
                    ctl_o           = PC_REG;
                    needs_resolve_o = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch/next-PC controller. Fetches the word at pc, classifies it, waits for a
// branch or register result when required, then issues exactly one pc_we strobe
// per instruction with pc_control/jmp_addr/branch_offset held stable.
//   clk, rst        clock, asynchronous active-high reset
//   pc              current PC from program_counter
//   imem_req/addr   fetch request (held until imem_ack) and address (= pc)
//   imem_ack/rdata  fetch completion and instruction word
//   stall           downstream hazard; freezes DECODE and UPDATE
//   branch_valid/taken, reg_valid   resolution inputs, sampled only in RESOLVE
//   instr, instr_valid              latched word and its decode pulse
//   pc_control, jmp_addr, branch_offset, pc_we   program_counter controls
//   fault           sticky timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module pc_sequencer
    import cpu_defs::*;
#(
    parameter int FETCH_TIMEOUT = 16,  // 0 disables the fetch timeout
    parameter int RESOLVE_MAX   = 8    // 0 disables the resolve timeout
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic        reg_valid,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [2:0]  pc_control,
    output logic [25:0] jmp_addr,
    output logic [15:0] branch_offset,
    output logic        pc_we,
    output logic        fault
);

    localparam int TMR_W = 16;

    seq_state_e        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [31:0]       instr_q, instr_d;
    logic [2:0]        ctl_q, ctl_d;
    logic [25:0]       jmp_q, jmp_d;
    logic [15:0]       off_q, off_d;
    logic              is_br_q, is_br_d;
    logic              fault_q, fault_d;

    logic [2:0]        cls_ctl;
    logic              cls_resolve;
    logic              cls_branch;
    logic              fetch_expired;
    logic              resolve_expired;

    instr_classifier u_classifier (
        .op_i            (instr_q[31:26]),
        .funct_i         (instr_q[5:0]),
        .ctl_o           (cls_ctl),
        .needs_resolve_o (cls_resolve),
        .is_branch_o     (cls_branch)
    );

    // One timer serves both FETCH and RESOLVE; it is cleared on entry to each.
    // "Expired" means this is the last permitted waiting cycle.
    assign fetch_expired   = (FETCH_TIMEOUT != 0) &&
                             (timer_q == TMR_W'(FETCH_TIMEOUT - 1));
    assign resolve_expired = (RESOLVE_MAX != 0) &&
                             (timer_q == TMR_W'(RESOLVE_MAX - 1));

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        instr_d     = instr_q;
        ctl_d       = ctl_q;
        jmp_d       = jmp_q;
        off_d       = off_q;
        is_br_d     = is_br_q;
        fault_d     = fault_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        pc_we       = 1'b0;

        case (state_q)
            ST_RESET_WAIT: begin
                timer_d = '0;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end else if (fetch_expired) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            // The decode pulse and the control capture happen on the same
            // (unstalled) cycle, so the controls become valid at DECODE exit.
            ST_DECODE: begin
                if (!stall) begin
                    instr_valid = 1'b1;
                    ctl_d       = cls_ctl;
                    jmp_d       = instr_q[25:0];
                    off_d       = instr_q[15:0];
                    is_br_d     = cls_branch;
                    timer_d     = '0;
                    state_d     = cls_resolve ? ST_RESOLVE : ST_UPDATE;
                end
            end

            // A valid result is checked before expiry so it wins a tie.
            ST_RESOLVE: begin
                if (is_br_q && branch_valid) begin
                    ctl_d   = branch_taken ? PC_BR : PC_SEQ;
                    state_d = ST_UPDATE;
                end else if (!is_br_q && reg_valid) begin
                    state_d = ST_UPDATE;
                end else if (resolve_expired) begin
                    fault_d = 1'b1;
                    ctl_d   = PC_SEQ;
                    jmp_d   = '0;
                    off_d   = '0;
                    state_d = ST_HALT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_UPDATE: begin
                if (!stall) begin
                    pc_we   = 1'b1;
                    ctl_d   = PC_SEQ;
                    jmp_d   = '0;
                    off_d   = '0;
                    timer_d = '0;
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: begin
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET_WAIT;
            timer_q <= '0;
            instr_q <= '0;
            ctl_q   <= PC_SEQ;
            jmp_q   <= '0;
            off_q   <= '0;
            is_br_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            instr_q <= instr_d;
            ctl_q   <= ctl_d;
            jmp_q   <= jmp_d;
            off_q   <= off_d;
            is_br_q <= is_br_d;
            fault_q <= fault_d;
        end
    end

    // Address is forced to zero outside FETCH; async reset of state_q drops it at once.
    assign imem_addr     = imem_req ? pc : '0;
    assign instr         = instr_q;
    assign pc_control    = ctl_q;
    assign jmp_addr      = jmp_q;
    assign branch_offset = off_q;
    assign fault         = fault_q;

endmodule
